// File: rtl/pipeline_stage_sequencer_pkg.sv
// Shared constants and types for the 5-stage pipeline sequencer:
// one-hot stage encodings, stage vector width, MEM timeout limit,
// FSM state type and the state-to-stage-vector decode.
package pipeline_stage_sequencer_pkg;

  localparam int STAGE_COUNT    = 5;
  localparam int TIMEOUT_CYCLES = 15;

  localparam logic [STAGE_COUNT-1:0] STAGE_IF  = 5'b00001;
  localparam logic [STAGE_COUNT-1:0] STAGE_ID  = 5'b00010;
  localparam logic [STAGE_COUNT-1:0] STAGE_EX  = 5'b00100;
  localparam logic [STAGE_COUNT-1:0] STAGE_MEM = 5'b01000;
  localparam logic [STAGE_COUNT-1:0] STAGE_WB  = 5'b10000;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } seq_state_t;

  // HALT (and any illegal encoding) shows an all-zero stage vector.
  function automatic logic [STAGE_COUNT-1:0] stage_onehot(input seq_state_t st);
    logic [STAGE_COUNT-1:0] v;
    case (st)
      ST_IF:   v = STAGE_IF;
      ST_ID:   v = STAGE_ID;
      ST_EX:   v = STAGE_EX;
      ST_MEM:  v = STAGE_MEM;
      ST_WB:   v = STAGE_WB;
      default: v = 5'b00000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/pipeline_stage_sequencer_if.sv
// Control/bus bundle between the decoder, the sequencer and the data bus.
// The master side drives decoded control and bus status; the slave side
// (the sequencer) drives the stage vector, PC and bus request.
interface pipeline_stage_sequencer_if
  import pipeline_stage_sequencer_pkg::*;
#(
  parameter int I_ADDR_WIDTH = 8,
  parameter int RETIRE_WIDTH = 16
);

  logic                    mem_access;
  logic                    mem_ready;
  logic                    branch_taken;
  logic [I_ADDR_WIDTH-1:0] branch_target;
  logic                    halt_req;
  logic [STAGE_COUNT-1:0]  pipeline_stage;
  logic [I_ADDR_WIDTH-1:0] program_counter;
  logic                    mem_req;
  logic                    pc_advance;
  logic                    halted;
  logic                    bus_error;
  logic [RETIRE_WIDTH-1:0] retired_count;

  modport master (
    output mem_access, mem_ready, branch_taken, branch_target, halt_req,
    input  pipeline_stage, program_counter, mem_req, pc_advance, halted,
           bus_error, retired_count
  );

  modport slave (
    input  mem_access, mem_ready, branch_taken, branch_target, halt_req,
    output pipeline_stage, program_counter, mem_req, pc_advance, halted,
           bus_error, retired_count
  );

endinterface

// File: rtl/pipeline_stage_sequencer_wait_counter.sv
// seq_wait_counter: clearable up-counter with a terminal-count flag used
// to bound MEM wait states. Only built when SEQ_TIMEOUT_EN is defined.
// tc is high while the counter holds LIMIT-1, i.e. during the LIMIT-th
// counted cycle, so the caller can act on the edge that reaches LIMIT.
`ifdef SEQ_TIMEOUT_EN
module seq_wait_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_r;

  // Count enabled cycles, saturating at LIMIT; clear wins over count.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_r <= CW'(0);
    end else if (en && (count_r != CW'(LIMIT))) begin
      count_r <= count_r + CW'(1);
    end
  end

  assign tc = (count_r == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/pipeline_stage_sequencer.sv
// pipeline_stage_sequencer: steps the 5-stage core IF->ID->EX->MEM->WB,
// holds the PC and retire counter, stretches MEM with bus wait states and
// stops in HALT on a WB halt request (left only by reset).
// Optional feature macro: SEQ_TIMEOUT_EN -- bounds MEM wait states to
// TIMEOUT_CYCLES and pulses bus_error on the forced MEM->WB move.
module pipeline_stage_sequencer
  import pipeline_stage_sequencer_pkg::*;
#(
  parameter int I_ADDR_WIDTH = 8,
  parameter int RETIRE_WIDTH = 16
) (
  input logic                      clk,
  input logic                      reset,
  pipeline_stage_sequencer_if.slave bus
);

  seq_state_t              state_r;
  seq_state_t              state_nx_s;
  logic [I_ADDR_WIDTH-1:0] pc_r;
  logic                    mem_acc_r;
  logic                    br_taken_r;
  logic [I_ADDR_WIDTH-1:0] br_target_r;
  logic [RETIRE_WIDTH-1:0] retired_r;
  logic                    mem_done_s;

`ifdef SEQ_TIMEOUT_EN
  logic mem_wait_s;
  logic timeout_s;
  logic bus_error_r;

  assign mem_wait_s = (state_r == ST_MEM) && mem_acc_r && !bus.mem_ready;

  seq_wait_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (state_r == ST_EX),
    .en    (mem_wait_s),
    .tc    (timeout_s)
  );

  // bus_error is high for the WB cycle that follows a timeout abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_error_r <= 1'b0;
    end else begin
      bus_error_r <= mem_wait_s && timeout_s;
    end
  end

  // MEM completes on mem_ready, on a non-bus instruction, or on timeout.
  assign mem_done_s = !mem_acc_r || bus.mem_ready || timeout_s;
  assign bus.bus_error = bus_error_r;
`else
  // Without the timeout, MEM waits on mem_ready indefinitely.
  assign mem_done_s = !mem_acc_r || bus.mem_ready;
  assign bus.bus_error = 1'b0;
`endif

  // Next-state decode for the stage FSM.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IF:   state_nx_s = ST_ID;
      ST_ID:   state_nx_s = ST_EX;
      ST_EX:   state_nx_s = ST_MEM;
      ST_MEM: begin
        if (mem_done_s) begin
          state_nx_s = ST_WB;
        end else begin
          state_nx_s = ST_MEM;
        end
      end
      ST_WB: begin
        if (bus.halt_req) begin
          state_nx_s = ST_HALT;
        end else begin
          state_nx_s = ST_IF;
        end
      end
      ST_HALT: state_nx_s = ST_HALT;
      default: state_nx_s = ST_IF;
    endcase
  end

  // State register, EX-stage latches, PC and retire counter updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IF;
      pc_r        <= I_ADDR_WIDTH'(0);
      mem_acc_r   <= 1'b0;
      br_taken_r  <= 1'b0;
      br_target_r <= I_ADDR_WIDTH'(0);
      retired_r   <= RETIRE_WIDTH'(0);
    end else begin
      state_r <= state_nx_s;
      if (state_r == ST_EX) begin
        mem_acc_r   <= bus.mem_access;
        br_taken_r  <= bus.branch_taken;
        br_target_r <= bus.branch_target;
      end
      if (state_r == ST_WB) begin
        pc_r      <= br_taken_r ? br_target_r : (pc_r + I_ADDR_WIDTH'(1));
        retired_r <= retired_r + RETIRE_WIDTH'(1);
      end
    end
  end

  assign bus.pipeline_stage  = stage_onehot(state_r);
  assign bus.program_counter = pc_r;
  assign bus.mem_req         = (state_r == ST_MEM) && mem_acc_r;
  assign bus.pc_advance      = (state_r == ST_WB);
  assign bus.halted          = (state_r == ST_HALT);
  assign bus.retired_count   = retired_r;

endmodule
